// File: rtl/proc_pkg.sv
// Shared opcode/funct encodings, pipeline-register layouts and the ALU helper
// for the 5-stage 16-bit processor.
package proc_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SUBI = 5'b01001;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_ALU  = 5'b11011;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_J    = 5'b00100;

  localparam logic [1:0] FN_ADD  = 2'b00;
  localparam logic [1:0] FN_SUB  = 2'b01;
  localparam logic [1:0] FN_XOR  = 2'b10;
  localparam logic [1:0] FN_ANDN = 2'b11;

  localparam logic [15:0] NOP_INST = {OP_NOP, 11'd0};

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] inst;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [4:0]  op;
    logic [1:0]  funct;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  dest;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_halt;
    logic        err;
    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] st_data;
    logic [2:0]  dest;
    logic        reg_write;
    logic        mem_rd;
    logic        mem_wr;
    logic        is_halt;
    logic        err;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  dest;
    logic        reg_write;
    logic [15:0] wdata;
  } mem_wb_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: 16'h0000, inst: NOP_INST};

  // Register-register ALU; a = Rs, b = Rt.
  function automatic logic [15:0] alu_calc(input logic [1:0] funct,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
    case (funct)
      FN_ADD:  return a + b;
      FN_SUB:  return b - a;
      FN_XOR:  return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// 8x16 register file, two combinational read ports, one write port; a read of
// the register being written this cycle returns the incoming data.
module proc_regfile
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd1,
  output logic [15:0] rd2,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd
);

  logic [15:0] regs_q [8];
  logic [15:0] regs_d [8];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reading the next-state array gives the write-before-read bypass for free.
  assign rd1 = regs_d[ra1];
  assign rd2 = regs_d[ra2];

endmodule

// File: rtl/pipelined_proc_hier.sv
// 5-stage in-order 16-bit CPU (IF/ID/EX/MEM/WB) with full forwarding, a one-cycle
// load-use stall, branches resolved in EX, and a sticky HALT that freezes the pipe.
module pipelined_proc_hier
  import proc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [15:0]      imem_addr,
  input  logic [15:0]      imem_data,
  output logic [15:0]      dmem_addr,
  output logic [15:0]      dmem_wdata,
  input  logic [15:0]      dmem_rdata,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic [15:0]      trace_pc,
  output logic [15:0]      trace_inst,
  output logic             trace_reg_write,
  output logic [2:0]       trace_wreg,
  output logic [15:0]      trace_wdata,
  output logic             halt,
  output logic             err,
  output logic             icache_req,
  output logic             icache_hit,
  output logic             dcache_req,
  output logic             dcache_hit,
  output logic [CNT_W-1:0] cycle_count
);

  logic [15:0]      pc_q, pc_d;
  if_id_t           if_id_q, if_id_d;
  id_ex_t           id_ex_q, id_ex_d, id_dec;
  ex_mem_t          ex_mem_q, ex_mem_d, ex_res;
  mem_wb_t          mem_wb_q, mem_wb_d;
  logic             halt_q, halt_d, err_q, err_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  logic [2:0]  id_rs, id_rt;
  logic [15:0] rf_rd1, rf_rd2;
  logic        id_use_rs, id_use_rt, load_use;
  logic [15:0] ex_a, ex_b;
  logic        br_taken;
  logic        halt_in_mem;

  assign id_rs = if_id_q.inst[10:8];
  assign id_rt = if_id_q.inst[7:5];

  proc_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (id_rs),
    .ra2 (id_rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (mem_wb_q.valid & mem_wb_q.reg_write),
    .wa  (mem_wb_q.dest),
    .wd  (mem_wb_q.wdata)
  );

  // ID: decode into ID/EX control; unknown opcodes travel as tagged NOPs.
  always_comb begin
    id_dec        = '0;
    id_dec.valid  = if_id_q.valid;
    id_dec.pc     = if_id_q.pc;
    id_dec.op     = if_id_q.inst[15:11];
    id_dec.funct  = if_id_q.inst[1:0];
    id_dec.rs     = id_rs;
    id_dec.rt     = id_rt;
    id_dec.rs_val = rf_rd1;
    id_dec.rt_val = rf_rd2;
    id_dec.imm    = {{11{if_id_q.inst[4]}}, if_id_q.inst[4:0]};
    id_use_rs     = 1'b0;
    id_use_rt     = 1'b0;
    if (if_id_q.valid) begin
      case (if_id_q.inst[15:11])
        OP_HALT: id_dec.is_halt = 1'b1;
        OP_NOP:  ;
        OP_ADDI, OP_SUBI, OP_LD: begin
          id_dec.reg_write = 1'b1;
          id_dec.dest      = id_rt;
          id_dec.mem_rd    = (if_id_q.inst[15:11] == OP_LD);
          id_use_rs        = 1'b1;
        end
        OP_ST: begin
          id_dec.mem_wr = 1'b1;
          id_use_rs     = 1'b1;
          id_use_rt     = 1'b1;
        end
        OP_LBI: begin
          id_dec.reg_write = 1'b1;
          id_dec.dest      = id_rs;
          id_dec.imm       = {{8{if_id_q.inst[7]}}, if_id_q.inst[7:0]};
        end
        OP_ALU: begin
          id_dec.reg_write = 1'b1;
          id_dec.dest      = if_id_q.inst[4:2];
          id_use_rs        = 1'b1;
          id_use_rt        = 1'b1;
        end
        OP_BEQZ: begin
          id_dec.imm = {{8{if_id_q.inst[7]}}, if_id_q.inst[7:0]};
          id_use_rs  = 1'b1;
        end
        OP_J: id_dec.imm = {{5{if_id_q.inst[10]}}, if_id_q.inst[10:0]};
        default: id_dec.err = 1'b1;
      endcase
    end
  end

  assign load_use = id_ex_q.valid && id_ex_q.mem_rd &&
                    ((id_use_rs && id_ex_q.dest == id_rs) ||
                     (id_use_rt && id_ex_q.dest == id_rt));

  // EX: operand forwarding (EX/MEM over MEM/WB over register file), ALU, branch.
  always_comb begin
    ex_a = id_ex_q.rs_val;
    ex_b = id_ex_q.rt_val;
    if (ex_mem_q.valid && ex_mem_q.reg_write && ex_mem_q.dest == id_ex_q.rs)
      ex_a = ex_mem_q.alu;
    else if (mem_wb_q.valid && mem_wb_q.reg_write && mem_wb_q.dest == id_ex_q.rs)
      ex_a = mem_wb_q.wdata;
    if (ex_mem_q.valid && ex_mem_q.reg_write && ex_mem_q.dest == id_ex_q.rt)
      ex_b = ex_mem_q.alu;
    else if (mem_wb_q.valid && mem_wb_q.reg_write && mem_wb_q.dest == id_ex_q.rt)
      ex_b = mem_wb_q.wdata;

    ex_res           = '0;
    ex_res.valid     = id_ex_q.valid;
    ex_res.st_data   = ex_b;
    ex_res.dest      = id_ex_q.dest;
    ex_res.reg_write = id_ex_q.reg_write;
    ex_res.mem_rd    = id_ex_q.mem_rd;
    ex_res.mem_wr    = id_ex_q.mem_wr;
    ex_res.is_halt   = id_ex_q.is_halt;
    ex_res.err       = id_ex_q.err;
    case (id_ex_q.op)
      OP_ADDI, OP_LD, OP_ST: ex_res.alu = ex_a + id_ex_q.imm;
      OP_SUBI:               ex_res.alu = id_ex_q.imm - ex_a;
      OP_LBI:                ex_res.alu = id_ex_q.imm;
      OP_ALU:                ex_res.alu = alu_calc(id_ex_q.funct, ex_a, ex_b);
      default:               ex_res.alu = '0;
    endcase
    br_taken = id_ex_q.valid &&
               ((id_ex_q.op == OP_BEQZ && ex_a == 16'h0000) || id_ex_q.op == OP_J);
  end

  assign halt_in_mem = ex_mem_q.valid & ex_mem_q.is_halt;
  assign halt        = halt_q | halt_in_mem;
  assign err         = err_q | (ex_mem_q.valid & ex_mem_q.err);

  // MEM/WB always drains so the instruction ahead of HALT still retires.
  always_comb begin
    pc_d               = pc_q;
    if_id_d            = if_id_q;
    id_ex_d            = id_ex_q;
    ex_mem_d           = ex_mem_q;
    mem_wb_d.valid     = ex_mem_q.valid;
    mem_wb_d.dest      = ex_mem_q.dest;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.wdata     = ex_mem_q.mem_rd ? dmem_rdata : ex_mem_q.alu;
    halt_d             = halt;
    err_d              = err;
    cycle_d            = halt ? cycle_q : cycle_q + CNT_W'(1);
    if (!halt) begin
      ex_mem_d = ex_res;
      if (br_taken) begin
        pc_d    = id_ex_q.pc + 16'd2 + id_ex_q.imm;
        if_id_d = IF_ID_BUBBLE;
        id_ex_d = '0;
      end else if (load_use) begin
        id_ex_d = '0;
      end else begin
        pc_d    = pc_q + 16'd2;
        if_id_d = '{valid: 1'b1, pc: pc_q, inst: imem_data};
        id_ex_d = id_dec;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      if_id_q  <= IF_ID_BUBBLE;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
      cycle_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
      cycle_q  <= cycle_d;
    end
  end

  assign imem_addr       = pc_q;
  assign dmem_addr       = ex_mem_q.alu;
  assign dmem_wdata      = ex_mem_q.st_data;
  assign dmem_rd         = ex_mem_q.valid & ex_mem_q.mem_rd;
  assign dmem_wr         = ex_mem_q.valid & ex_mem_q.mem_wr;
  assign trace_pc        = pc_q;
  assign trace_inst      = if_id_q.inst;
  assign trace_reg_write = mem_wb_q.valid & mem_wb_q.reg_write;
  assign trace_wreg      = mem_wb_q.dest;
  assign trace_wdata     = mem_wb_q.wdata;
  assign icache_req      = 1'b0;
  assign icache_hit      = 1'b0;
  assign dcache_req      = 1'b0;
  assign dcache_hit      = 1'b0;
  assign cycle_count     = cycle_q;

endmodule

// File: tb/tb_pipelined_proc_hier.sv
// Directed-program bench: small programs in a model instruction memory, WB and
// store activity logged at negedge and compared against hand-derived results.
module tb_pipelined_proc_hier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_rd, dmem_wr;
  logic [15:0] trace_pc, trace_inst, trace_wdata;
  logic        trace_reg_write;
  logic [2:0]  trace_wreg;
  logic        halt, err, icache_req, icache_hit, dcache_req, dcache_hit;
  logic [31:0] cycle_count;

  pipelined_proc_hier #(.RESET_PC(16'h0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .trace_pc(trace_pc), .trace_inst(trace_inst),
    .trace_reg_write(trace_reg_write), .trace_wreg(trace_wreg), .trace_wdata(trace_wdata),
    .halt(halt), .err(err),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  logic [15:0] imem [0:63];
  logic [15:0] dmem [0:63];
  assign imem_data  = imem[imem_addr[6:1]];
  assign dmem_rdata = dmem[dmem_addr[6:1]];
  always @(posedge clk) if (dmem_wr) dmem[dmem_addr[6:1]] <= dmem_wdata;

  int tb_cyc;
  always @(posedge clk or posedge rst) if (rst) tb_cyc <= 0; else tb_cyc <= tb_cyc + 1;

  // Activity log, cleared while reset is held.
  int          wr_n, mw_n;
  logic [2:0]  wr_reg [32];
  logic [15:0] wr_dat [32];
  int          wr_cyc [32];
  logic [15:0] mw_addr, mw_data, ld_addr, ld_data;
  always @(negedge clk) begin
    if (rst) begin
      wr_n <= 0;
      mw_n <= 0;
    end else begin
      if (trace_reg_write && wr_n < 32) begin
        wr_reg[wr_n] <= trace_wreg;
        wr_dat[wr_n] <= trace_wdata;
        wr_cyc[wr_n] <= tb_cyc;
        wr_n         <= wr_n + 1;
      end
      if (dmem_wr) begin
        mw_addr <= dmem_addr;
        mw_data <= dmem_wdata;
        mw_n    <= mw_n + 1;
      end
      if (dmem_rd) begin
        ld_addr <= dmem_addr;
        ld_data <= dmem_rdata;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [15:0] enc_lbi(input logic [2:0] rs, input logic [7:0] imm);
    return {5'b11000, rs, imm};
  endfunction
  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [4:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [15:0] enc_alu(input logic [2:0] rs, input logic [2:0] rt,
                                          input logic [2:0] rd, input logic [1:0] fn);
    return {5'b11011, rs, rt, rd, fn};
  endfunction
  function automatic logic [15:0] enc_beqz(input logic [2:0] rs, input logic [7:0] imm);
    return {5'b01100, rs, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0800;
  endtask

  // Leaves the bench at the first negedge after release, with no edge since reset.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_to_halt();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = halt;
    end
    n_total++;
    if (!seen) $display("FAIL halt_timeout: halt=%b after 100 cycles, required 1", halt);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_imem();
    do_reset();
    n_total++; if (imem_addr !== 16'h0000) $display("FAIL rst_pc: got %h required 0000", imem_addr); else n_pass++;
    n_total++; if ({halt, err} !== 2'b00) $display("FAIL rst_halt_err: got %b required 00", {halt, err}); else n_pass++;
    n_total++; if (cycle_count !== 32'd0) $display("FAIL rst_cycles: got %0d required 0", cycle_count); else n_pass++;
    n_total++; if ({trace_reg_write, dmem_wr, dmem_rd} !== 3'b000) $display("FAIL rst_enables: got %b required 000", {trace_reg_write, dmem_wr, dmem_rd}); else n_pass++;
    n_total++; if (trace_inst !== 16'h0800) $display("FAIL rst_inst: got %h required 0800", trace_inst); else n_pass++;
    n_total++; if ({icache_req, icache_hit, dcache_req, dcache_hit} !== 4'b0000) $display("FAIL cache_ties: got %b required 0000", {icache_req, icache_hit, dcache_req, dcache_hit}); else n_pass++;
    $display("test_reset done: pc=%h cycles=%0d", imem_addr, cycle_count);
  endtask

  task automatic test_basic();
    logic [2:0]  er [3] = '{3'd1, 3'd2, 3'd3};
    logic [15:0] ed [3] = '{16'h0005, 16'h0003, 16'h0008};
    clear_imem();
    imem[0] = enc_lbi(3'd1, 8'd5);
    imem[1] = enc_lbi(3'd2, 8'd3);
    imem[2] = enc_alu(3'd1, 3'd2, 3'd3, 2'b00);
    imem[3] = 16'h0000;
    do_reset();
    run_to_halt();
    n_total++; if (cycle_count !== 32'd6) $display("FAIL basic_cycles_at_halt: got %0d required 6", cycle_count); else n_pass++;
    repeat (5) @(negedge clk);
    n_total++; if (cycle_count !== 32'd6) $display("FAIL basic_cycle_freeze: got %0d required 6", cycle_count); else n_pass++;
    n_total++; if (halt !== 1'b1) $display("FAIL basic_halt_sticky: got %b required 1", halt); else n_pass++;
    n_total++; if (wr_n !== 3) $display("FAIL basic_wr_count: got %0d required 3", wr_n); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (wr_reg[i] !== er[i] || wr_dat[i] !== ed[i] || wr_cyc[i] - wr_cyc[0] !== i)
        $display("FAIL basic_wb%0d: got R%0d=%h at +%0d required R%0d=%h at +%0d",
                 i, wr_reg[i], wr_dat[i], wr_cyc[i] - wr_cyc[0], er[i], ed[i], i);
      else n_pass++;
    end
    $display("test_basic done: %0d writes, halt at cycle_count=%0d", wr_n, cycle_count);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  er [3] = '{3'd1, 3'd2, 3'd3};
    logic [15:0] ed [3] = '{16'h0007, 16'h0008, 16'hFFF8};
    clear_imem();
    imem[0] = enc_lbi(3'd1, 8'd7);
    imem[1] = enc_i(5'b01000, 3'd1, 3'd2, 5'd1);
    imem[2] = enc_i(5'b01001, 3'd2, 3'd3, 5'd0);
    imem[3] = 16'h0000;
    do_reset();
    run_to_halt();
    repeat (3) @(negedge clk);
    n_total++; if (wr_n !== 3) $display("FAIL b2b_wr_count: got %0d required 3", wr_n); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (wr_reg[i] !== er[i] || wr_dat[i] !== ed[i] || wr_cyc[i] - wr_cyc[0] !== i)
        $display("FAIL b2b_wb%0d: got R%0d=%h at +%0d required R%0d=%h at +%0d",
                 i, wr_reg[i], wr_dat[i], wr_cyc[i] - wr_cyc[0], er[i], ed[i], i);
      else n_pass++;
    end
    $display("test_back_to_back done: %0d writes", wr_n);
  endtask

  task automatic test_load_use();
    logic [2:0]  er [3] = '{3'd1, 3'd4, 3'd5};
    logic [15:0] ed [3] = '{16'h0010, 16'h0010, 16'h0011};
    int          et [3] = '{0, 2, 4};
    clear_imem();
    imem[0] = enc_lbi(3'd1, 8'h10);
    imem[1] = enc_i(5'b10000, 3'd1, 3'd1, 5'd0);
    imem[2] = enc_i(5'b10001, 3'd1, 3'd4, 5'd0);
    imem[3] = enc_i(5'b01000, 3'd4, 3'd5, 5'd1);
    imem[4] = 16'h0000;
    do_reset();
    run_to_halt();
    repeat (3) @(negedge clk);
    n_total++; if (mw_n !== 1 || mw_addr !== 16'h0010 || mw_data !== 16'h0010)
      $display("FAIL ld_store: got n=%0d addr=%h data=%h required n=1 addr=0010 data=0010", mw_n, mw_addr, mw_data);
    else n_pass++;
    n_total++; if (ld_addr !== 16'h0010 || ld_data !== 16'h0010)
      $display("FAIL ld_read: got addr=%h data=%h required 0010/0010", ld_addr, ld_data);
    else n_pass++;
    n_total++; if (wr_n !== 3) $display("FAIL ld_wr_count: got %0d required 3", wr_n); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (wr_reg[i] !== er[i] || wr_dat[i] !== ed[i] || wr_cyc[i] - wr_cyc[0] !== et[i])
        $display("FAIL ld_wb%0d: got R%0d=%h at +%0d required R%0d=%h at +%0d",
                 i, wr_reg[i], wr_dat[i], wr_cyc[i] - wr_cyc[0], er[i], ed[i], et[i]);
      else n_pass++;
    end
    $display("test_load_use done: store %h->%h, %0d writes", mw_data, mw_addr, wr_n);
  endtask

  task automatic test_branch();
    logic [2:0]  er [3] = '{3'd7, 3'd3, 3'd4};
    logic [15:0] ed [3] = '{16'h0009, 16'h0003, 16'h0004};
    int          et [3] = '{0, 4, 6};
    clear_imem();
    imem[0] = enc_lbi(3'd7, 8'd9);
    imem[1] = enc_beqz(3'd0, 8'd4);
    imem[2] = enc_lbi(3'd1, 8'd1);
    imem[3] = enc_lbi(3'd2, 8'd2);
    imem[4] = enc_lbi(3'd3, 8'd3);
    imem[5] = enc_beqz(3'd7, 8'd4);
    imem[6] = enc_lbi(3'd4, 8'd4);
    imem[7] = 16'h0000;
    do_reset();
    run_to_halt();
    repeat (3) @(negedge clk);
    n_total++; if (wr_n !== 3) $display("FAIL br_wr_count: got %0d required 3", wr_n); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (wr_reg[i] !== er[i] || wr_dat[i] !== ed[i] || wr_cyc[i] - wr_cyc[0] !== et[i])
        $display("FAIL br_wb%0d: got R%0d=%h at +%0d required R%0d=%h at +%0d",
                 i, wr_reg[i], wr_dat[i], wr_cyc[i] - wr_cyc[0], er[i], ed[i], et[i]);
      else n_pass++;
    end
    $display("test_branch done: %0d writes", wr_n);
  endtask

  task automatic test_illegal();
    clear_imem();
    imem[0] = 16'hF800;
    imem[1] = enc_lbi(3'd1, 8'd1);
    imem[2] = 16'h0000;
    do_reset();
    run_to_halt();
    repeat (3) @(negedge clk);
    n_total++; if (err !== 1'b1) $display("FAIL ill_err: got %b required 1", err); else n_pass++;
    n_total++; if (mw_n !== 0) $display("FAIL ill_no_store: got %0d stores required 0", mw_n); else n_pass++;
    n_total++; if (wr_n !== 1 || wr_reg[0] !== 3'd1 || wr_dat[0] !== 16'h0001)
      $display("FAIL ill_writes: got n=%0d R%0d=%h required n=1 R1=0001", wr_n, wr_reg[0], wr_dat[0]);
    else n_pass++;
    $display("test_illegal done: err=%b writes=%0d", err, wr_n);
  endtask

  task automatic test_async_reset();
    clear_imem();
    imem[0] = 16'hF800;
    imem[1] = enc_lbi(3'd1, 8'd1);
    imem[2] = {5'b00100, 11'h7FC};
    do_reset();
    repeat (20) @(negedge clk);
    n_total++; if (cycle_count !== 32'd20 || err !== 1'b1)
      $display("FAIL pre_rst: got cycles=%0d err=%b required 20/1", cycle_count, err);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (imem_addr !== 16'h0000) $display("FAIL async_pc: got %h required 0000", imem_addr); else n_pass++;
    n_total++; if ({halt, err} !== 2'b00 || cycle_count !== 32'd0)
      $display("FAIL async_status: got halt/err=%b cycles=%0d required 00/0", {halt, err}, cycle_count);
    else n_pass++;
    n_total++; if ({trace_reg_write, dmem_wr, dmem_rd} !== 3'b000)
      $display("FAIL async_enables: got %b required 000", {trace_reg_write, dmem_wr, dmem_rd});
    else n_pass++;
    @(posedge clk);
    #2 rst = 1'b0;
    $display("test_async_reset done: pc=%h", imem_addr);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_illegal();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
